// File: rtl/regbank_writeback_if.sv
// -----------------------------------------------------------------------------
// regbank_writeback_if
// Bundles every signal between the execute/memory/decode stages and the
// register-bank write front end.
//   master : pipeline side (drives results, issue info, decode selects)
//   slave  : regbank_writeback (drives readies, busy flags, bank write port)
// Signals:
//   bank_ready                       bank initialised and accepting writes
//   alu_valid/alu_rd/alu_data/alu_ready   ALU result channel
//   lsu_valid/lsu_rd/lsu_data/lsu_ready   load result channel
//   issue_valid/issue_rd             destination marked busy at issue
//   rs1_sel/rs2_sel, rs1_busy/rs2_busy    decode hazard query
//   reg_w/rd_sel/rd_data             registered bank write port
//   any_busy                         OR of all scoreboard bits
//
// Handshake: a result transfers on a clock edge where both valid and ready
// are high. A producer holds valid, rd and data stable until that edge;
// ready is combinational, may be low while valid is high, and never depends
// on the bank write port.
// -----------------------------------------------------------------------------
interface regbank_writeback_if #(
  parameter int BW = 5,
  parameter int RW = 32
);
  logic          bank_ready;
  logic          alu_valid;
  logic [BW-1:0] alu_rd;
  logic [RW-1:0] alu_data;
  logic          alu_ready;
  logic          lsu_valid;
  logic [BW-1:0] lsu_rd;
  logic [RW-1:0] lsu_data;
  logic          lsu_ready;
  logic          issue_valid;
  logic [BW-1:0] issue_rd;
  logic [BW-1:0] rs1_sel;
  logic [BW-1:0] rs2_sel;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          reg_w;
  logic [BW-1:0] rd_sel;
  logic [RW-1:0] rd_data;
  logic          any_busy;

  modport master (
    output bank_ready, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, rs1_sel, rs2_sel,
    input  alu_ready, lsu_ready, rs1_busy, rs2_busy, reg_w, rd_sel, rd_data, any_busy
  );

  modport slave (
    input  bank_ready, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, rs1_sel, rs2_sel,
    output alu_ready, lsu_ready, rs1_busy, rs2_busy, reg_w, rd_sel, rd_data, any_busy
  );
endinterface

// File: rtl/regbank_writeback.sv
// -----------------------------------------------------------------------------
// regbank_writeback
// Write-side front end of the integer register bank. Accepts ALU and load
// results (load has fixed priority), drives one registered bank write per
// cycle, and keeps a per-register busy scoreboard for the decode stall logic.
// Ports:
//   clk          clock
//   rst          synchronous reset, active-low
//   bus          regbank_writeback_if.slave (all handshake and bank signals)
//   state_dbg_o  current FSM state (0 = INIT, 1 = RUN)
// -----------------------------------------------------------------------------
module regbank_writeback #(
  parameter int BANK_WIDTH     = 5,
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  regbank_writeback_if.slave  bus,
  output logic                state_dbg_o
);

  localparam int NUM_REGS = 1 << BANK_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [NUM_REGS-1:0]       sb_q, sb_d;
  logic                      reg_w_q, reg_w_d;
  logic [BANK_WIDTH-1:0]     rd_sel_q, rd_sel_d;
  logic [REGISTER_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                      run;
  logic                      lsu_acc;
  logic                      alu_acc;
  logic                      acc;
  logic [BANK_WIDTH-1:0]     acc_rd;
  logic [REGISTER_WIDTH-1:0] acc_data;

  // Arbitration. Traffic only moves while running and the bank is up, so a
  // cycle in which the bank drops never completes a handshake.
  always_comb begin
    run      = (state_q == ST_RUN) && bus.bank_ready;
    lsu_acc  = run && bus.lsu_valid;
    alu_acc  = run && bus.alu_valid && !bus.lsu_valid;
    acc      = lsu_acc || alu_acc;
    acc_rd   = lsu_acc ? bus.lsu_rd   : bus.alu_rd;
    acc_data = lsu_acc ? bus.lsu_data : bus.alu_data;
  end

  assign bus.lsu_ready = lsu_acc;
  assign bus.alu_ready = alu_acc;

  always_comb begin
    state_d   = state_q;
    sb_d      = sb_q;
    reg_w_d   = 1'b0;
    rd_sel_d  = rd_sel_q;
    rd_data_d = rd_data_q;

    case (state_q)
      ST_INIT: state_d = bus.bank_ready ? ST_RUN : ST_INIT;
      ST_RUN:  state_d = bus.bank_ready ? ST_RUN : ST_INIT;
      default: state_d = ST_INIT;
    endcase

    if (!run) begin
      // Bank is (re)initialising: nothing pending survives, issue is ignored.
      sb_d = '0;
    end else begin
      if (acc) begin
        sb_d[acc_rd] = 1'b0;
        // x0 completes its handshake but is never written.
        if (acc_rd != '0) begin
          reg_w_d   = 1'b1;
          rd_sel_d  = acc_rd;
          rd_data_d = acc_data;
        end
      end
      // Applied after the clear: a new producer issued on the same edge as
      // the old one's writeback keeps the register busy.
      if (bus.issue_valid && (bus.issue_rd != '0)) begin
        sb_d[bus.issue_rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      sb_q      <= '0;
      reg_w_q   <= 1'b0;
      rd_sel_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sb_q      <= sb_d;
      reg_w_q   <= reg_w_d;
      rd_sel_q  <= rd_sel_d;
      rd_data_q <= rd_data_d;
    end
  end

  // The scoreboard bit clears at the accept edge, but the bank only holds the
  // value one cycle later, so the in-flight write port also counts as busy.
  always_comb begin
    bus.rs1_busy = (bus.rs1_sel != '0) &&
                   (sb_q[bus.rs1_sel] || (reg_w_q && (rd_sel_q == bus.rs1_sel)));
    bus.rs2_busy = (bus.rs2_sel != '0) &&
                   (sb_q[bus.rs2_sel] || (reg_w_q && (rd_sel_q == bus.rs2_sel)));
  end

  assign bus.any_busy = |sb_q;
  assign bus.reg_w    = reg_w_q;
  assign bus.rd_sel   = rd_sel_q;
  assign bus.rd_data  = rd_data_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_regbank_writeback.sv
module tb_regbank_writeback;
  localparam int BW = 5;
  localparam int RW = 32;
  localparam int EW = 1 + BW + RW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic state_dbg;

  always #5 clk = ~clk;

  regbank_writeback_if #(.BW(BW), .RW(RW)) bus();

  regbank_writeback #(.BANK_WIDTH(BW), .REGISTER_WIDTH(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- vectors ----------------
  // One record per clock cycle. ecomb = {alu_ready, lsu_ready, rs1_busy,
  // rs2_busy, any_busy} just before the edge; ew/erd/edat = bank write
  // expected just after the edge.
  typedef struct {
    logic          rstn, bank, av;
    logic [BW-1:0] ard;
    logic [RW-1:0] adat;
    logic          lv;
    logic [BW-1:0] lrd;
    logic [RW-1:0] ldat;
    logic          iv;
    logic [BW-1:0] ird, rs1, rs2;
    logic          chk;
    logic [4:0]    ecomb;
    logic          ew;
    logic [BW-1:0] erd;
    logic [RW-1:0] edat;
  } vec_t;

  function automatic vec_t mk(input int rstn, input int bank,
                              input int av, input int ard, input logic [RW-1:0] adat,
                              input int lv, input int lrd, input logic [RW-1:0] ldat,
                              input int iv, input int ird, input int rs1, input int rs2,
                              input int chk, input logic [4:0] ecomb,
                              input int ew, input int erd, input logic [RW-1:0] edat);
    vec_t t;
    t.rstn  = (rstn != 0);
    t.bank  = (bank != 0);
    t.av    = (av != 0);
    t.ard   = BW'(ard);
    t.adat  = adat;
    t.lv    = (lv != 0);
    t.lrd   = BW'(lrd);
    t.ldat  = ldat;
    t.iv    = (iv != 0);
    t.ird   = BW'(ird);
    t.rs1   = BW'(rs1);
    t.rs2   = BW'(rs2);
    t.chk   = (chk != 0);
    t.ecomb = ecomb;
    t.ew    = (ew != 0);
    t.erd   = BW'(erd);
    t.edat  = edat;
    return t;
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t t);
    @(negedge clk);
    rst             = t.rstn;
    bus.bank_ready  = t.bank;
    bus.alu_valid   = t.av;
    bus.alu_rd      = t.ard;
    bus.alu_data    = t.adat;
    bus.lsu_valid   = t.lv;
    bus.lsu_rd      = t.lrd;
    bus.lsu_data    = t.ldat;
    bus.issue_valid = t.iv;
    bus.issue_rd    = t.ird;
    bus.rs1_sel     = t.rs1;
    bus.rs2_sel     = t.rs2;
    #1;
    if (t.chk)
      check("comb", 64'({bus.alu_ready, bus.lsu_ready, bus.rs1_busy, bus.rs2_busy, bus.any_busy}),
            64'(t.ecomb));
    exp_q.push_back({t.ew, t.erd, t.edat});
  endtask

  // Monitor: every driven cycle has exactly one expected bank-port entry.
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("reg_w", 64'(bus.reg_w), 64'(e[EW-1]));
      if (e[EW-1]) begin
        check("rd_sel", 64'(bus.rd_sel), 64'(e[RW+BW-1:RW]));
        check("rd_data", 64'(bus.rd_data), 64'(e[RW-1:0]));
      end
    end
  end

  vec_t tbl[23];

  // ---------------- test ----------------
  initial begin
    bus.bank_ready  = 1'b0;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_rd      = '0;
    bus.lsu_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1_sel     = '0;
    bus.rs2_sel     = '0;

    //           rstn bank av ard adat            lv lrd ldat     iv ird rs1 rs2 chk ecomb     ew erd edat
    tbl[0]  = mk(1, 1, 1, 1, 32'hA1,        0, 0, 32'h0,  0, 0, 0, 0, 1, 5'b00000, 0, 0, 32'h0);
    tbl[1]  = mk(1, 1, 1, 1, 32'hA1,        0, 0, 32'h0,  0, 0, 1, 0, 1, 5'b10000, 1, 1, 32'hA1);
    tbl[2]  = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  1, 5, 1, 5, 1, 5'b00100, 0, 0, 32'h0);
    tbl[3]  = mk(1, 1, 1, 5, 32'hDEADBEEF,  0, 0, 32'h0,  0, 0, 5, 0, 1, 5'b10101, 1, 5, 32'hDEADBEEF);
    tbl[4]  = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 5, 0, 1, 5'b00100, 0, 0, 32'h0);
    tbl[5]  = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 5, 0, 1, 5'b00000, 0, 0, 32'h0);
    tbl[6]  = mk(1, 1, 1, 4, 32'h22,        1, 3, 32'h11, 0, 0, 3, 4, 1, 5'b01000, 1, 3, 32'h11);
    tbl[7]  = mk(1, 1, 1, 4, 32'h22,        0, 0, 32'h0,  0, 0, 3, 4, 1, 5'b10100, 1, 4, 32'h22);
    tbl[8]  = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 3, 4, 1, 5'b00010, 0, 0, 32'h0);
    tbl[9]  = mk(1, 1, 1, 0, 32'hFFFFFFFF,  0, 0, 32'h0,  0, 0, 0, 0, 1, 5'b10000, 0, 0, 32'h0);
    tbl[10] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  1, 0, 0, 0, 1, 5'b00000, 0, 0, 32'h0);
    tbl[11] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  1, 7, 0, 7, 1, 5'b00000, 0, 0, 32'h0);
    tbl[12] = mk(1, 1, 1, 7, 32'h77,        0, 0, 32'h0,  1, 7, 0, 7, 1, 5'b10011, 1, 7, 32'h77);
    tbl[13] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 7, 1, 5'b00011, 0, 0, 32'h0);
    tbl[14] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 7, 1, 5'b00011, 0, 0, 32'h0);
    tbl[15] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  1, 9, 9, 7, 1, 5'b00011, 0, 0, 32'h0);
    tbl[16] = mk(1, 0, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 9, 7, 1, 5'b00111, 0, 0, 32'h0);
    tbl[17] = mk(1, 0, 1, 2, 32'h2,         0, 0, 32'h0,  0, 0, 9, 7, 1, 5'b00000, 0, 0, 32'h0);
    tbl[18] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  1, 9, 9, 0, 1, 5'b00000, 0, 0, 32'h0);
    tbl[19] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 9, 0, 1, 5'b00000, 0, 0, 32'h0);
    tbl[20] = mk(1, 1, 1, 6, 32'h66,        0, 0, 32'h0,  0, 0, 6, 0, 1, 5'b10000, 1, 6, 32'h66);
    tbl[21] = mk(1, 0, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 6, 0, 1, 5'b00100, 0, 0, 32'h0);
    tbl[22] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 0, 1, 5'b00000, 0, 0, 32'h0);

    // Reset and reset-state check.
    drive(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 32'h0));
    drive(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 32'h0));
    @(posedge clk);
    #2;
    check("rst_reg_w", 64'(bus.reg_w), 64'(0));
    check("rst_rd_sel", 64'(bus.rd_sel), 64'(0));
    check("rst_rd_data", 64'(bus.rd_data), 64'(0));
    check("rst_any_busy", 64'(bus.any_busy), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));

    // Bank not ready for 10 cycles: ALU offer must not be accepted.
    for (int i = 0; i < 10; i++)
      drive(mk(1, 0, 1, 3, 32'h33, 0, 0, 32'h0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 32'h0));
    check("state_init", 64'(state_dbg), 64'(0));

    for (int i = 0; i < 23; i++) drive(tbl[i]);

    // Reset while a write is on the bank port.
    drive(mk(1, 1, 1, 8, 32'h88, 0, 0, 32'h0, 1, 10, 0, 0, 1, 5'b10000, 1, 8, 32'h88));
    drive(mk(0, 1, 1, 9, 32'h99, 0, 0, 32'h0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 32'h0));
    @(posedge clk);
    #2;
    check("midrst_rd_sel", 64'(bus.rd_sel), 64'(0));
    check("midrst_rd_data", 64'(bus.rd_data), 64'(0));
    check("midrst_any_busy", 64'(bus.any_busy), 64'(0));
    check("midrst_state", 64'(state_dbg), 64'(0));
    drive(mk(1, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 10, 8, 1, 5'b00000, 0, 0, 32'h0));
    drive(mk(1, 1, 1, 11, 32'hBB, 0, 0, 32'h0, 0, 0, 0, 0, 1, 5'b10000, 1, 11, 32'hBB));
    drive(mk(1, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 32'h0));

    // Random ALU/LSU contention, nonzero destinations, no issues.
    for (int i = 0; i < 24; i++) begin
      int av, lv, ard, lrd;
      logic [RW-1:0] ad, ld;
      logic [4:0] ec;
      av  = int'($urandom_range(0, 1));
      lv  = int'($urandom_range(0, 1));
      ard = int'($urandom_range(1, 31));
      lrd = int'($urandom_range(1, 31));
      ad  = $urandom;
      ld  = $urandom;
      ec  = {((av != 0) && (lv == 0)), (lv != 0), 3'b000};
      if (lv != 0)
        drive(mk(1, 1, av, ard, ad, lv, lrd, ld, 0, 0, 0, 0, 1, ec, 1, lrd, ld));
      else if (av != 0)
        drive(mk(1, 1, av, ard, ad, lv, lrd, ld, 0, 0, 0, 0, 1, ec, 1, ard, ad));
      else
        drive(mk(1, 1, av, ard, ad, lv, lrd, ld, 0, 0, 0, 0, 1, ec, 0, 0, 32'h0));
    end

    repeat (2) @(posedge clk);
    #2;
    check("drain", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
